ex_div: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands and the DIV/DIVU decode.
- Produces the quotient (to LO) and the remainder (to HI).
- Raises the EX stall request (stall[2]) while a division is in flight, so ID/EX and the earlier stages hold.

---
 rtl/ex_div_if.sv | 26 ++
 rtl/ex_div.sv | 143 ++++++++++++++
 tb/tb_ex_div.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// EX-stage divider handshake bundle: operands/controls from the pipeline, stall/results back.
// The divider owns stall_req, done and the result buses; the pipeline owns everything else.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             hold;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, dividend, divisor, cancel, hold,
        input  stall_req, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, dividend, divisor, cancel, hold,
        output stall_req, done, quotient, remainder
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider (DIV/DIVU): WIDTH+1 cycles start-to-done, 1 cycle on divide-by-zero.
// stall_req holds the pipeline until done; hold keeps done and the results parked in DONE.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   trial_shift;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_ok;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // One restoring step: dvd_q shifts its top bit into the partial remainder
    // while quotient bits fill in from the bottom.
    always_comb begin
        dividend_abs = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        divisor_abs  = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
        trial_shift  = {rem_q, dvd_q[WIDTH-1]};
        trial_ok     = (trial_shift >= {1'b0, dsr_q});
        trial_diff   = trial_shift[WIDTH-1:0] - dsr_q;
        step_rem     = trial_ok ? trial_diff : trial_shift[WIDTH-1:0];
        step_quo     = {dvd_q[WIDTH-2:0], trial_ok};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = done_q;

        if (bus.cancel) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_d = 1'b0;
                    if (bus.start) begin
                        cnt_d  = '0;
                        rem_d  = '0;
                        dvd_d  = dividend_abs;
                        dsr_d  = divisor_abs;
                        qneg_d = (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]) & bus.signed_div;
                        rneg_d = bus.dividend[WIDTH-1] & bus.signed_div;
                        if (bus.divisor == '0) begin
                            // Divide-by-zero bypasses the iteration entirely.
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            quo_d   = '1;
                            rmd_d   = bus.dividend;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_d = step_rem;
                    dvd_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quo_d   = qneg_q ? -step_quo : step_quo;
                        rmd_d   = rneg_q ? -step_rem : step_rem;
                    end
                end
                S_DONE: begin
                    if (!bus.hold) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

    // Stall must cover the very cycle start first appears, hence combinational.
    assign bus.stall_req = bus.start & ~bus.cancel & (state_q != S_DONE) & ~rst;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed cases from the pipeline's point of view plus randomized operands.
module tb_ex_div;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   last_done_cyc;

    ex_div_if #(.WIDTH(32)) dif ();

    ex_div #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero for signed operands.
    function automatic void ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sd) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    // Called at a point just after a falling edge with the divider idle.
    task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                           input int hold_n, input bit chain, input string tag);
        logic [31:0] eq, er;
        int lat, stalls, ndone, exp_lat;
        ref_div(sd, a, b, eq, er);
        exp_lat        = (b == 32'd0) ? 1 : 33;
        dif.start      = 1'b1;
        dif.signed_div = sd;
        dif.dividend   = a;
        dif.divisor    = b;
        dif.cancel     = 1'b0;
        dif.hold       = (hold_n > 0);
        lat    = 0;
        stalls = 0;
        #1;
        while (dif.done !== 1'b1 && lat < 100) begin
            if (dif.stall_req === 1'b1) stalls++;
            @(negedge clk);
            #1;
            lat++;
        end
        last_done_cyc = cyc;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        ndone = 0;
        while (dif.done === 1'b1 && ndone < 20) begin
            ndone++;
            check({tag, "_quotient"}, dif.quotient, eq);
            check({tag, "_remainder"}, dif.remainder, er);
            check({tag, "_stall_in_done"}, 32'(dif.stall_req), 32'd0);
            if (ndone == hold_n + 1) begin
                dif.hold = 1'b0;
                if (!chain) dif.start = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        check({tag, "_done_cycles"}, 32'(ndone), 32'(hold_n + 1));
        check({tag, "_quotient_kept"}, dif.quotient, eq);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rsd;
        int          first_done;
        int          seen;
        checks         = 0;
        failures       = 0;
        cyc            = 0;
        last_done_cyc  = 0;
        rst            = 1'b1;
        dif.start      = 1'b0;
        dif.signed_div = 1'b0;
        dif.dividend   = '0;
        dif.divisor    = '0;
        dif.cancel     = 1'b0;
        dif.hold       = 1'b0;

        #12;
        dif.start = 1'b1;
        #1;
        check("reset_done", 32'(dif.done), 32'd0);
        check("reset_quotient", dif.quotient, 32'd0);
        check("reset_remainder", dif.remainder, 32'd0);
        check("reset_stall", 32'(dif.stall_req), 32'd0);
        dif.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, 0, 1'b0, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0, "div_m100_7");
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 0, 1'b0, "div_100_m7");
        run_div(1'b0, 32'h1234_5678, 32'd0, 0, 1'b0, "divu_by_zero");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_overflow");
        run_div(1'b0, 32'd9, 32'd2, 3, 1'b0, "hold3");

        run_div(1'b0, 32'd9, 32'd2, 0, 1'b1, "b2b_first");
        first_done = last_done_cyc;
        run_div(1'b0, 32'd8, 32'd4, 0, 1'b0, "b2b_second");
        check("b2b_spacing", 32'(last_done_cyc - first_done), 32'd34);

        // Cancel in the tenth RUN cycle, together with the flush dropping start.
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.dividend   = 32'd9;
        dif.divisor    = 32'd2;
        repeat (10) @(negedge clk);
        #1;
        check("cancel_pre_stall", 32'(dif.stall_req), 32'd1);
        dif.cancel = 1'b1;
        #1;
        check("cancel_stall_comb", 32'(dif.stall_req), 32'd0);
        dif.start = 1'b0;
        @(negedge clk);
        #1;
        dif.cancel = 1'b0;
        check("cancel_stall_after", 32'(dif.stall_req), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (dif.done === 1'b1) seen++;
        end
        check("cancel_no_done", 32'(seen), 32'd0);
        check("cancel_result_untouched", dif.quotient, 32'd2);
        run_div(1'b0, 32'd8, 32'd4, 0, 1'b0, "after_cancel");

        // Asynchronous reset in the middle of an operation.
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.dividend   = 32'd1000;
        dif.divisor    = 32'd3;
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_quotient", dif.quotient, 32'd0);
        check("rst_mid_remainder", dif.remainder, 32'd0);
        check("rst_mid_done", 32'(dif.done), 32'd0);
        check("rst_mid_stall", 32'(dif.stall_req), 32'd0);
        dif.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        run_div(1'b0, 32'd1000, 32'd3, 0, 1'b0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                3:       begin rb = $urandom; ra = ra >> $urandom_range(0, 31); end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(rsd, ra, rb, int'($urandom_range(0, 2)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
